// File: rtl/player_hit_pkg.sv
// player_hit_pkg: shared state type, widths and culprit-select helper for player_hit_manager
package player_hit_pkg;

    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

    localparam int LIVES_W     = 3;
    localparam int FRAME_CNT_W = 8;
    localparam int MAX_POOPS   = 32;

    // Keeps only the lowest set bit (v & -v); all-zero input gives all-zero output
    function automatic logic [MAX_POOPS-1:0] lsb_onehot(input logic [MAX_POOPS-1:0] v);
        return v & (~v + MAX_POOPS'(1));
    endfunction

endpackage

// File: rtl/frame_down_counter.sv
// frame_down_counter: loadable down-counter stepped by frame strobes, flags the 1->0 step
module frame_down_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q;

    assign tc_o = en_i && cnt_q == W'(1);

    // Load wins over decrement; the count parks at zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= val_i;
        else if (en_i && cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

endmodule

// File: rtl/player_hit_manager.sv
// player_hit_manager: counts player hits, kills the culprit poop, runs invulnerability and game-over.
// Optional INVULN_BLINK_EN: blink the player during the invulnerability window.
module player_hit_manager
    import player_hit_pkg::*;
#(
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 8,
    parameter int NUM_POOPS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startOfFrame,
    input  logic                 SingleHitPulse,
    input  logic [NUM_POOPS-1:0] poopsDrawingRequest,
    input  logic                 gameRestart,
    output logic [NUM_POOPS-1:0] poopKillPulse,
    output logic                 hitEvent,
    output logic [LIVES_W-1:0]   lives,
    output logic                 playerVisible,
    output logic                 gameOver
);
    if (LIVES_INIT < 1 || LIVES_INIT > 7 || INVULN_FRAMES < 1 || INVULN_FRAMES > 255 ||
        BLINK_FRAMES < 1 || BLINK_FRAMES > INVULN_FRAMES ||
        NUM_POOPS < 1 || NUM_POOPS > MAX_POOPS) begin : g_bad_params
        $error("player_hit_manager: parameter out of range");
    end

    state_t               state_q;
    logic                 hit_q;
    logic [NUM_POOPS-1:0] req_q;
    logic [NUM_POOPS-1:0] kill_q;
    logic [NUM_POOPS-1:0] kill_d;
    logic                 hit_ev_q;
    logic [LIVES_W-1:0]   lives_q;
    logic                 vis_q;
    logic                 over_q;
    logic                 hit_take;
    logic                 last_life;
    logic                 inv_load;
    logic                 inv_en;
    logic                 inv_tc;
    logic                 blink_tc;
    logic                 vis_entry;

    // req_q lags one cycle so it holds the collision cycle that raised the pulse
    assign hit_take  = SingleHitPulse && !hit_q && state_q == ALIVE && !gameRestart;
    assign last_life = lives_q == LIVES_W'(1);
    assign kill_d    = NUM_POOPS'(lsb_onehot(MAX_POOPS'(req_q)));
    assign inv_load  = gameRestart || hit_take;
    assign inv_en    = startOfFrame && state_q == INVULN;

    frame_down_counter #(.W(FRAME_CNT_W)) u_invuln (
        .clk_i (clk),
        .rst_i (reset),
        .load_i(inv_load),
        .en_i  (inv_en),
        .val_i (gameRestart ? '0 : FRAME_CNT_W'(INVULN_FRAMES)),
        .tc_o  (inv_tc)
    );

`ifdef INVULN_BLINK_EN
    frame_down_counter #(.W(FRAME_CNT_W)) u_blink (
        .clk_i (clk),
        .rst_i (reset),
        .load_i(inv_load || blink_tc),
        .en_i  (inv_en),
        .val_i (gameRestart ? '0 : FRAME_CNT_W'(BLINK_FRAMES)),
        .tc_o  (blink_tc)
    );
    assign vis_entry = 1'b0;
`else
    assign blink_tc  = 1'b0;
    assign vis_entry = 1'b1;
`endif

    assign poopKillPulse = kill_q;
    assign hitEvent      = hit_ev_q;
    assign lives         = lives_q;
    assign playerVisible = vis_q;
    assign gameOver      = over_q;

    // Hit-accounting FSM with registered outputs; restart overrides everything else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ALIVE;
            hit_q    <= 1'b0;
            req_q    <= '0;
            kill_q   <= '0;
            hit_ev_q <= 1'b0;
            lives_q  <= LIVES_W'(LIVES_INIT);
            vis_q    <= 1'b1;
            over_q   <= 1'b0;
        end else begin
            hit_q    <= SingleHitPulse;
            req_q    <= poopsDrawingRequest;
            kill_q   <= hit_take ? kill_d : '0;
            hit_ev_q <= hit_take;
            if (gameRestart) begin
                state_q <= ALIVE;
                lives_q <= LIVES_W'(LIVES_INIT);
                vis_q   <= 1'b1;
                over_q  <= 1'b0;
            end else if (hit_take) begin
                lives_q <= lives_q - LIVES_W'(1);
                state_q <= last_life ? DEAD : INVULN;
                vis_q   <= last_life ? 1'b0 : vis_entry;
                over_q  <= last_life;
            end else if (inv_tc) begin
                state_q <= ALIVE;
                vis_q   <= 1'b1;
            end else if (state_q == INVULN && blink_tc) begin
                vis_q   <= !vis_q;
            end
        end
    end

endmodule

// File: tb/tb_player_hit_manager.sv
// tb_player_hit_manager: directed scoreboard bench for player_hit_manager (default parameters)
module tb_player_hit_manager;

    logic       clk = 1'b0;
    logic       reset;
    logic       sof;
    logic       pulse;
    logic       restart;
    logic [7:0] req;
    logic [7:0] kill;
    logic       hit_ev;
    logic [2:0] lives;
    logic       vis;
    logic       over;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] kill;
        logic [2:0] lives;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

`ifdef INVULN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    always #5 clk = ~clk;

    player_hit_manager dut (
        .clk                (clk),
        .reset              (reset),
        .startOfFrame       (sof),
        .SingleHitPulse     (pulse),
        .poopsDrawingRequest(req),
        .gameRestart        (restart),
        .poopKillPulse      (kill),
        .hitEvent           (hit_ev),
        .lives              (lives),
        .playerVisible      (vis),
        .gameOver           (over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every kill/hitEvent must match the next queued counted hit; anything else is spurious
    always @(negedge clk) begin
        if (!reset && (hit_ev || kill != 8'h00)) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {23'd0, kill, hit_ev}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("hit_kill", kill, mon_e.kill);
                chk("hit_event", hit_ev, 1);
                chk("hit_lives", lives, mon_e.lives);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        sof   = 1'b1;
        pulse = 1'b0;
        tick();
        sof = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // Collision cycle with vector v, then the detector pulse rises one cycle later
    task automatic do_hit(input logic [7:0] v, input bit counted, input logic [7:0] exp_kill,
                          input logic [2:0] exp_lives, input bit with_sof);
        req = v;
        tick();
        req   = 8'h00;
        pulse = 1'b1;
        sof   = with_sof;
        if (counted) sb.push_back('{exp_kill, exp_lives});
        tick();
        sof = 1'b0;
        @(negedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        reset   = 1'b1;
        sof     = 1'b0;
        pulse   = 1'b0;
        restart = 1'b0;
        req     = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_lives", lives, 3);
        chk("reset_vis", vis, 1);
        chk("reset_over", over, 0);
        chk("reset_kill", kill, 0);
        chk("reset_hitev", hit_ev, 0);

        do_hit(8'b0010_0100, 1, 8'b0000_0100, 3'd2, 0);
        chk("t1_lives", lives, 2);
        chk("t1_vis_entry", vis, !BLINK);
        frame();
        chk("blink_f1", vis, !BLINK);
        frames(7);
        chk("blink_f8", vis, 1);
        frames(2);
        do_hit(8'b0000_1000, 0, 8'h00, 3'd0, 0);
        chk("t2_ignored_lives", lives, 2);
        frames(6);
        chk("blink_f16", vis, !BLINK);
        frames(43);
        do_hit(8'h01, 0, 8'h00, 3'd0, 0);
        chk("t2_f59_ignored_lives", lives, 2);
        frame();
        chk("t2_exit_vis", vis, 1);

        do_hit(8'b1000_0000, 1, 8'b1000_0000, 3'd1, 0);
        frames(60);
        do_hit(8'h00, 1, 8'h00, 3'd0, 0);
        chk("t3_dead_lives", lives, 0);
        chk("t3_dead_over", over, 1);
        chk("t3_dead_vis", vis, 0);
        frame();
        do_hit(8'hFF, 0, 8'h00, 3'd0, 0);
        chk("t3_dead_ignored_lives", lives, 0);
        chk("t3_dead_still_over", over, 1);

        frame();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_lives", lives, 3);
        chk("restart_over", over, 0);
        chk("restart_vis", vis, 1);

        frame();
        req = 8'h10;
        tick();
        req     = 8'h00;
        pulse   = 1'b1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        @(negedge clk);
        #1;
        chk("t4_restart_hit_lives", lives, 3);
        frame();
        do_hit(8'b0000_0011, 1, 8'b0000_0001, 3'd2, 0);
        frames(60);

        do_hit(8'h40, 1, 8'h40, 3'd1, 1);
        frames(59);
        do_hit(8'h02, 0, 8'h00, 3'd0, 0);
        chk("sof_hit_f59_lives", lives, 1);
        frame();
        do_hit(8'h02, 1, 8'h02, 3'd0, 0);
        chk("sof_hit_dead_over", over, 1);

        frame();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        frame();
        do_hit(8'h04, 1, 8'h04, 3'd2, 0);
        frames(3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_lives", lives, 3);
        chk("async_rst_vis", vis, 1);
        chk("async_rst_over", over, 0);
        tick();
        reset = 1'b0;
        frame();
        do_hit(8'h08, 1, 8'h08, 3'd2, 0);
        frames(2);
        chk("final_sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
